app_csr_bank: RTL and testbench
===============================

// Module: app_csr_bank
//
// PURPOSE
//  Parametrised MMIO CSR bank between the host MMIO decode and an application.
//  Provides DFH, AFU ID, scratch and cycle-counter registers, plus NUM_APP_CSRS
//  generic read and write CSRs.
//  Reads are pipelined with a fixed 2-cycle latency and return the transaction ID.
//  Adds read-acknowledge pulses for clear-on-read application registers and a
//  clearable free-running counter.
//
// PARAMETERS
//  NUM_APP_CSRS   8      generic app CSRs (1..64); read and write CSRs are unrelated
//  ADDR_W         8      MMIO address width, 64-bit word index
//  TID_W          9      MMIO read transaction ID width
//  CNT_W          40     cycle counter width (1..64)
//  DFH_VALUE      64'h1000010000000000  value returned at word 0
//
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high reset
//  mmio_wr_valid  in   1                   host write strobe, one word per cycle
//  mmio_wr_addr   in   ADDR_W              write word index
//  mmio_wr_data   in   64                  write data
//  mmio_rd_valid  in   1                   host read request; no backpressure
//  mmio_rd_addr   in   ADDR_W              read word index
//  mmio_rd_tid    in   TID_W               read transaction ID
//  mmio_rsp_valid out  1                   read response valid, one cycle
//  mmio_rsp_tid   out  TID_W               returned transaction ID
//  mmio_rsp_data  out  64                  returned data
//  afu_id         in   128                 application AFU ID, held static
//  app_rd_data    in   64*NUM_APP_CSRS     app read CSR values; CSR i is [64i+63:64i]
//  app_rd_ack     out  NUM_APP_CSRS        one-hot pulse: app read CSR i was sampled
//  app_wr_en      out  NUM_APP_CSRS        one-hot pulse: app write CSR i was written
//  app_wr_data    out  64                  data for the app_wr_en pulse
//
// BEHAVIOUR
//  Map (word index), read side:
//   - 0 = DFH_VALUE
//   - 1 = afu_id[63:0]
//   - 2 = afu_id[127:64]
//   - 3 = scratch (R/W)
//   - 4 = cycle counter, zero-extended to 64 bits
//   - 5..7 = reserved, read 0
//   - 8+i = app_rd_data CSR i, for i < NUM_APP_CSRS
//   - any other address reads 0
//  Map, write side:
//   - 3 = scratch
//   - 4 = clears the counter (data ignored)
//   - 8+i = app write CSR i
//   - writes to all other addresses are dropped
//  Read pipeline:
//   - Request at cycle T: addr/tid registered at T.
//   - Data muxed from live state at T+1.
//   - mmio_rsp_valid/tid/data registered at T+2.
//   - Back-to-back reads are accepted every cycle; responses return in order, one per cycle.
//   - app_rd_ack[i] pulses at T+1, the cycle app_rd_data CSR i is sampled. Only for valid
//     app addresses.
//  Write path:
//   - Write at T: app_wr_en[i] and app_wr_data are registered and visible at T+1 for exactly
//     one cycle.
//   - Scratch updates at T+1.
//   - A read of scratch issued at T+1 returns the new value.
//   - Same-cycle read and write to scratch: the read returns the old value.
//  Counter:
//   - Increments every cycle. Wraps from 2^CNT_W-1 to 0.
//   - A write to word 4 at T makes the counter 0 at T+1; the clear wins over the increment.
//   - A read at T samples the counter value at T+1.
//  Reset values:
//   - mmio_rsp_valid=0, mmio_rsp_tid=0, mmio_rsp_data=0
//   - app_rd_ack=0, app_wr_en=0, app_wr_data=0
//   - scratch=0, counter=0, pipeline valids=0
//  Reset mid-operation:
//   - In-flight reads are discarded.
//   - No response is issued for requests accepted before or during reset.
//   - Requests presented while reset=1 are ignored.
//  Address compare uses the full ADDR_W bits; no aliasing.
//
// TESTING
//  - After reset: read word 0 tid=5 -> rsp at +2 cycles, data=DFH_VALUE, tid=5; all outputs
//    0 during reset.
//  - Write word 3 = 64'hDEADBEEF_CAFEF00D, then read word 3 -> that value. Same-cycle
//    read+write to word 3 -> old value.
//  - Write word 8+2 = 64'h1234 -> app_wr_en=3'b100 (one-hot bit 2) and app_wr_data=64'h1234
//    for exactly one cycle. Write word 8+NUM_APP_CSRS -> no pulse.
//  - Reads of words 9,1,2,20 on consecutive cycles, tids 1..4:
//    - responses in order: app CSR 1, afu_id lo, afu_id hi, 0
//    - app_rd_ack[1] pulses once
//  - CNT_W=4: counter wraps 15->0. Write word 4 when counter=9 -> next read shows a small
//    post-clear value. Clear on the same cycle as the wrap -> 0.
//  - Issue a read, assert reset at T+1 -> no mmio_rsp_valid. After release, a new read
//    responds normally.

Source files
------------

// File: rtl/app_csr_bank_if.sv
// app_csr_bank_if: host MMIO write, read-request and read-response signals.
interface app_csr_bank_if #(
    parameter int ADDR_W = 8,
    parameter int TID_W  = 9
);
    logic              mmio_wr_valid;
    logic [ADDR_W-1:0] mmio_wr_addr;
    logic [63:0]       mmio_wr_data;
    logic              mmio_rd_valid;
    logic [ADDR_W-1:0] mmio_rd_addr;
    logic [TID_W-1:0]  mmio_rd_tid;
    logic              mmio_rsp_valid;
    logic [TID_W-1:0]  mmio_rsp_tid;
    logic [63:0]       mmio_rsp_data;
    modport master (
        output mmio_wr_valid, mmio_wr_addr, mmio_wr_data, mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );
    modport slave (
        input  mmio_wr_valid, mmio_wr_addr, mmio_wr_data, mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data
    );
endinterface

// File: rtl/app_csr_bank.sv
// app_csr_bank: MMIO CSR bank with DFH/AFU ID/scratch/counter words, generic app CSRs,
// a fixed 2-cycle read pipeline and read/write strobes towards the application.
module app_csr_bank #(
    parameter int          NUM_APP_CSRS = 8,
    parameter int          ADDR_W       = 8,
    parameter int          TID_W        = 9,
    parameter int          CNT_W        = 40,
    parameter logic [63:0] DFH_VALUE    = 64'h1000010000000000
) (
    input  logic                      clk,
    input  logic                      reset,
    app_csr_bank_if.slave             bus,
    input  logic [127:0]              afu_id,
    input  logic [64*NUM_APP_CSRS-1:0] app_rd_data,
    output logic [NUM_APP_CSRS-1:0]   app_rd_ack,
    output logic [NUM_APP_CSRS-1:0]   app_wr_en,
    output logic [63:0]               app_wr_data
);
    logic                    rd_v_q;
    logic [ADDR_W-1:0]       rd_addr_q;
    logic [TID_W-1:0]        rd_tid_q;
    logic [63:0]             rd_scr_q;
    logic                    rsp_v_q;
    logic [TID_W-1:0]        rsp_tid_q;
    logic [63:0]             rsp_data_q, rd_data_d;
    logic [63:0]             scratch_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_APP_CSRS-1:0] ack_q, ack_d, wr_en_q, wr_en_d;
    logic [63:0]             wr_data_q;
    logic                    wr_scr, wr_cnt;

    // Widened compare so high addresses never alias onto low words.
    function automatic logic hit(input logic [ADDR_W-1:0] a, input int w);
        return 64'(a) == 64'(w);
    endfunction

    always_comb begin
        wr_scr = bus.mmio_wr_valid && hit(bus.mmio_wr_addr, 3);
        wr_cnt = bus.mmio_wr_valid && hit(bus.mmio_wr_addr, 4);
        cnt_d  = wr_cnt ? '0 : cnt_q + CNT_W'(1);
        for (int i = 0; i < NUM_APP_CSRS; i++) begin
            ack_d[i]   = bus.mmio_rd_valid && hit(bus.mmio_rd_addr, 8 + i);
            wr_en_d[i] = bus.mmio_wr_valid && hit(bus.mmio_wr_addr, 8 + i);
        end
        // Scratch comes from the request-cycle snapshot so a same-cycle write is not seen.
        rd_data_d = hit(rd_addr_q, 0) ? DFH_VALUE :
                    hit(rd_addr_q, 1) ? afu_id[63:0] :
                    hit(rd_addr_q, 2) ? afu_id[127:64] :
                    hit(rd_addr_q, 3) ? rd_scr_q :
                    hit(rd_addr_q, 4) ? 64'(cnt_q) : '0;
        for (int i = 0; i < NUM_APP_CSRS; i++)
            if (hit(rd_addr_q, 8 + i)) rd_data_d = app_rd_data[64*i +: 64];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_tid_q   <= '0;
            rd_scr_q   <= '0;
            rsp_v_q    <= 1'b0;
            rsp_tid_q  <= '0;
            rsp_data_q <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_v_q    <= bus.mmio_rd_valid;
            rd_addr_q <= bus.mmio_rd_addr;
            rd_tid_q  <= bus.mmio_rd_tid;
            rd_scr_q  <= scratch_q;
            rsp_v_q   <= rd_v_q;
            if (rd_v_q) begin
                rsp_tid_q  <= rd_tid_q;
                rsp_data_q <= rd_data_d;
            end
            if (wr_scr) scratch_q <= bus.mmio_wr_data;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= |wr_en_d ? bus.mmio_wr_data : '0;
        end
    end

    assign bus.mmio_rsp_valid = rsp_v_q;
    assign bus.mmio_rsp_tid   = rsp_tid_q;
    assign bus.mmio_rsp_data  = rsp_data_q;
    assign app_rd_ack         = ack_q;
    assign app_wr_en          = wr_en_q;
    assign app_wr_data        = wr_data_q;
endmodule

// File: tb/tb_app_csr_bank.sv
// tb_app_csr_bank: directed checks of the CSR map, read pipeline, app strobes,
// counter wrap/clear and reset behaviour (CNT_W=4, 8 app CSRs).
module tb_app_csr_bank;
    localparam int N = 8;
    localparam logic [63:0] DFH = 64'h1000010000000000;
    localparam logic [127:0] AFU = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic clk = 1'b0;
    logic reset;
    logic [127:0] afu_id;
    logic [64*N-1:0] app_rd_data;
    logic [N-1:0] app_rd_ack, app_wr_en;
    logic [63:0] app_wr_data;
    int n_run = 0;
    int n_fail = 0;

    app_csr_bank_if #(.ADDR_W(8), .TID_W(9)) bus ();

    app_csr_bank #(.NUM_APP_CSRS(N), .ADDR_W(8), .TID_W(9), .CNT_W(4), .DFH_VALUE(DFH)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .afu_id(afu_id),
        .app_rd_data(app_rd_data),
        .app_rd_ack(app_rd_ack),
        .app_wr_en(app_wr_en),
        .app_wr_data(app_wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic v, input logic [7:0] a, input logic [63:0] d);
        bus.mmio_wr_valid = v;
        bus.mmio_wr_addr  = a;
        bus.mmio_wr_data  = d;
    endtask

    task automatic rd(input logic v, input logic [7:0] a, input logic [8:0] t);
        bus.mmio_rd_valid = v;
        bus.mmio_rd_addr  = a;
        bus.mmio_rd_tid   = t;
    endtask

    initial begin
        afu_id = AFU;
        for (int i = 0; i < N; i++) app_rd_data[64*i +: 64] = {32'hA0A0A0A0, 32'(i)};
        reset = 1'b1;
        wr(0, 0, 0);
        rd(0, 0, 0);
        repeat (3) tick();
        chk("rst_rsp_valid", 64'(bus.mmio_rsp_valid), 0);
        chk("rst_rsp_tid", 64'(bus.mmio_rsp_tid), 0);
        chk("rst_rsp_data", bus.mmio_rsp_data, 0);
        chk("rst_rd_ack", 64'(app_rd_ack), 0);
        chk("rst_wr_en", 64'(app_wr_en), 0);
        chk("rst_wr_data", app_wr_data, 0);
        rd(1, 0, 7);
        tick();
        reset = 1'b0;
        rd(1, 0, 5);
        tick();
        chk("rst_req_ignored", 64'(bus.mmio_rsp_valid), 0);
        rd(0, 0, 0);
        tick();
        chk("dfh_valid", 64'(bus.mmio_rsp_valid), 1);
        chk("dfh_tid", 64'(bus.mmio_rsp_tid), 5);
        chk("dfh_data", bus.mmio_rsp_data, DFH);
        tick();
        chk("rsp_one_cycle", 64'(bus.mmio_rsp_valid), 0);

        wr(1, 3, 64'hDEADBEEF_CAFEF00D);
        tick();
        wr(0, 0, 0);
        rd(1, 3, 6);
        tick();
        rd(0, 0, 0);
        tick();
        chk("scratch_tid", 64'(bus.mmio_rsp_tid), 6);
        chk("scratch_rd", bus.mmio_rsp_data, 64'hDEADBEEF_CAFEF00D);
        wr(1, 3, 64'h1111);
        rd(1, 3, 7);
        tick();
        wr(0, 0, 0);
        rd(0, 0, 0);
        tick();
        chk("scratch_same_cycle_old", bus.mmio_rsp_data, 64'hDEADBEEF_CAFEF00D);
        rd(1, 3, 8);
        tick();
        rd(0, 0, 0);
        tick();
        chk("scratch_new", bus.mmio_rsp_data, 64'h1111);

        wr(1, 10, 64'h1234);
        tick();
        wr(0, 0, 0);
        chk("app_wr_en2", 64'(app_wr_en), 64'h04);
        chk("app_wr_data2", app_wr_data, 64'h1234);
        tick();
        chk("app_wr_en_gone", 64'(app_wr_en), 0);
        chk("app_wr_data_gone", app_wr_data, 0);
        wr(1, 15, 64'h77);
        tick();
        wr(1, 16, 64'h55);
        chk("app_wr_en7", 64'(app_wr_en), 64'h80);
        tick();
        wr(0, 0, 0);
        chk("app_wr_oob", 64'(app_wr_en), 0);

        rd(1, 9, 1);
        tick();
        rd(1, 1, 2);
        chk("ack1", 64'(app_rd_ack), 64'h02);
        tick();
        rd(1, 2, 3);
        chk("ack1_once", 64'(app_rd_ack), 0);
        chk("seq1_tid", 64'(bus.mmio_rsp_tid), 1);
        chk("seq1_data", bus.mmio_rsp_data, 64'hA0A0A0A0_00000001);
        tick();
        rd(1, 20, 4);
        chk("seq2_tid", 64'(bus.mmio_rsp_tid), 2);
        chk("seq2_data", bus.mmio_rsp_data, AFU[63:0]);
        tick();
        rd(0, 0, 0);
        chk("seq3_tid", 64'(bus.mmio_rsp_tid), 3);
        chk("seq3_data", bus.mmio_rsp_data, AFU[127:64]);
        tick();
        chk("seq4_valid", 64'(bus.mmio_rsp_valid), 1);
        chk("seq4_tid", 64'(bus.mmio_rsp_tid), 4);
        chk("seq4_data", bus.mmio_rsp_data, 0);
        tick();
        chk("seq_done", 64'(bus.mmio_rsp_valid), 0);

        // Clear at W: counter is k-1 at cycle W+k.
        wr(1, 4, 64'hFFFF);
        tick();
        wr(0, 0, 0);
        repeat (14) tick();
        rd(1, 4, 9);
        tick();
        rd(1, 4, 10);
        tick();
        rd(0, 0, 0);
        chk("cnt15_tid", 64'(bus.mmio_rsp_tid), 9);
        chk("cnt15", bus.mmio_rsp_data, 15);
        tick();
        chk("cnt_wrap", bus.mmio_rsp_data, 0);
        repeat (8) tick();
        wr(1, 4, 0);
        tick();
        wr(0, 0, 0);
        rd(1, 4, 11);
        tick();
        rd(0, 0, 0);
        tick();
        chk("cnt_post_clear", bus.mmio_rsp_data, 1);
        repeat (13) tick();
        wr(1, 4, 0);
        rd(1, 4, 12);
        tick();
        wr(0, 0, 0);
        rd(0, 0, 0);
        tick();
        chk("cnt_clear_at_wrap_tid", 64'(bus.mmio_rsp_tid), 12);
        chk("cnt_clear_at_wrap", bus.mmio_rsp_data, 0);

        rd(1, 0, 13);
        tick();
        rd(0, 0, 0);
        reset = 1'b1;
        tick();
        chk("midrst_no_rsp", 64'(bus.mmio_rsp_valid), 0);
        tick();
        reset = 1'b0;
        chk("midrst_no_rsp2", 64'(bus.mmio_rsp_valid), 0);
        rd(1, 0, 14);
        tick();
        rd(1, 3, 15);
        tick();
        rd(0, 0, 0);
        chk("post_rst_valid", 64'(bus.mmio_rsp_valid), 1);
        chk("post_rst_tid", 64'(bus.mmio_rsp_tid), 14);
        chk("post_rst_data", bus.mmio_rsp_data, DFH);
        tick();
        chk("post_rst_scratch", bus.mmio_rsp_data, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
